gmii_tx_framer: RTL and testbench

- Transmit MAC framer that sits directly upstream of the GMII-to-RGMII DDR output stage, in the same gmii_clk domain.
- Converts a byte-wide packet stream (valid/ready, sop/eop) into GMII frames on gmii_den/gmii_dout: preamble, SFD, payload, zero padding to minimum length, IEEE 802.3 CRC-32 FCS.
- Enforces the inter-frame gap. Aborts frames on underrun or oversize.

---
 rtl/gmii_tx_framer_if.sv | 16 +
 rtl/gmii_tx_framer.sv | 205 ++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake between a packet source and gmii_tx_framer.
//   in_valid  source -> framer  byte on in_data is valid
//   in_sop    source -> framer  byte is the first of a packet
//   in_eop    source -> framer  byte is the last of a packet
//   in_data   source -> framer  payload byte
//   in_ready  framer -> source  byte is taken when in_valid & in_ready
interface gmii_tx_framer_if;
    logic       in_valid;
    logic       in_sop;
    logic       in_eop;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, in_sop, in_eop, in_data, input in_ready);
    modport slave  (input in_valid, in_sop, in_eop, in_data, output in_ready);
endinterface

// File: rtl/gmii_tx_framer.sv
// Transmit MAC framer: turns a sop/eop byte stream into GMII frames
// (preamble, SFD, payload, zero padding, CRC-32 FCS) and enforces the
// inter-frame gap. Frames are aborted on source underrun or oversize.
// Ports:
//   gmii_clk    transmit byte clock
//   rst         synchronous active-high reset
//   stream      byte-stream handshake (slave side)
//   gmii_den    GMII TX enable, registered
//   gmii_dout   GMII TX data, registered, 0x00 whenever gmii_den is low
//   frame_done  pulse in the first gmii_den-low cycle after a good frame
//   underrun    pulse when a frame is aborted for missing payload bytes
//   oversize    pulse when a frame is aborted for exceeding MAX_FRAME
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1518,
    parameter int IFG_CYCLES   = 12,
    parameter int PAD_EN       = 1,
    parameter int FCS_EN       = 1
) (
    input  logic             gmii_clk,
    input  logic             rst,
    gmii_tx_framer_if.slave  stream,
    output logic             gmii_den,
    output logic [7:0]       gmii_dout,
    output logic             frame_done,
    output logic             underrun,
    output logic             oversize
);
    localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME - 4);
    localparam logic [15:0] PAY_LIMIT  = 16'(MAX_FRAME - 4);
    localparam logic [15:0] PRE_LAST   = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST   = 16'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DISCARD, IFG
    } state_t;

    // Every state decides what goes on the wire in the following cycle, so
    // gmii_den/gmii_dout come straight from flops.
    state_t      state_q, state_d;
    logic        den_q, den_d;
    logic [7:0]  dout_q, dout_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;      // payload + pad bytes of this frame
    logic [15:0] aux_q, aux_d;      // preamble / FCS byte / IFG cycle index
    logic        abort_q, abort_d;  // frame was cut short: no frame_done
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic        oversize_q, oversize_d;
    logic        ready;
    logic [15:0] cnt_inc;
    logic [31:0] fcs_word;

    // Reflected CRC-32 (poly 0xEDB88320), one byte LSB-first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign cnt_inc  = cnt_q + 16'd1;
    assign fcs_word = ~crc_q;

    // NOTE: every signal gets a default at the top of always_comb so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        den_d        = 1'b0;
        dout_d       = 8'h00;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        aux_d        = aux_q;
        abort_d      = abort_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        oversize_d   = 1'b0;
        ready        = 1'b0;

        case (state_q)
            IDLE: begin
                if (stream.in_valid && stream.in_sop) begin
                    // The sop byte stays on the bus until the SFD cycle.
                    state_d = (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
                    den_d   = 1'b1;
                    dout_d  = 8'h55;
                    aux_d   = 16'd1;
                    crc_d   = 32'hFFFFFFFF;
                    cnt_d   = 16'd0;
                    abort_d = 1'b0;
                end else begin
                    // Stray bytes outside a packet are swallowed.
                    ready = stream.in_valid;
                end
            end
            PREAMBLE: begin
                den_d  = 1'b1;
                dout_d = 8'h55;
                aux_d  = aux_q + 16'd1;
                if (aux_q == PRE_LAST) state_d = SFD;
            end
            SFD: begin
                den_d   = 1'b1;
                dout_d  = 8'hD5;
                state_d = DATA;
            end
            DATA: begin
                // This also covers the cycle in which the SFD is on the wire.
                ready = 1'b1;
                if (!stream.in_valid) begin
                    state_d    = DISCARD;
                    underrun_d = 1'b1;
                    abort_d    = 1'b1;
                end else begin
                    den_d  = 1'b1;
                    dout_d = stream.in_data;
                    crc_d  = crc_byte(crc_q, stream.in_data);
                    cnt_d  = cnt_inc;
                    if (stream.in_eop) begin
                        aux_d = 16'd0;
                        if (PAD_EN != 0 && cnt_inc < PAD_TARGET) state_d = PAD;
                        else if (FCS_EN != 0)                    state_d = FCS;
                        else                                     state_d = IFG;
                    end else if (cnt_inc == PAY_LIMIT) begin
                        // Limit byte still goes out; the wire drops after it.
                        state_d    = DISCARD;
                        oversize_d = 1'b1;
                        abort_d    = 1'b1;
                    end
                end
            end
            PAD: begin
                den_d = 1'b1;
                crc_d = crc_byte(crc_q, 8'h00);
                cnt_d = cnt_inc;
                if (cnt_inc >= PAD_TARGET) begin
                    aux_d   = 16'd0;
                    state_d = (FCS_EN != 0) ? FCS : IFG;
                end
            end
            FCS: begin
                den_d  = 1'b1;
                dout_d = fcs_word[{aux_q[1:0], 3'b000} +: 8];
                aux_d  = aux_q + 16'd1;
                if (aux_q[1:0] == 2'd3) begin
                    aux_d   = 16'd0;
                    state_d = IFG;
                end
            end
            DISCARD: begin
                ready = 1'b1;
                if (stream.in_valid && stream.in_eop) begin
                    aux_d   = 16'd0;
                    state_d = IFG;
                end
            end
            IFG: begin
                // First IFG cycle still shows the last frame byte, so the
                // pulse registered here lands on the first den-low cycle.
                frame_done_d = (aux_q == 16'd0) && !abort_q;
                aux_d        = aux_q + 16'd1;
                if (aux_q >= IFG_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            den_q        <= 1'b0;
            dout_q       <= 8'h00;
            crc_q        <= 32'hFFFFFFFF;
            cnt_q        <= 16'd0;
            aux_q        <= 16'd0;
            abort_q      <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            oversize_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            den_q        <= den_d;
            dout_q       <= dout_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            aux_q        <= aux_d;
            abort_q      <= abort_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            oversize_q   <= oversize_d;
        end
    end

    assign stream.in_ready = ready & ~rst;
    assign gmii_den        = den_q;
    assign gmii_dout       = dout_q;
    assign frame_done      = frame_done_q;
    assign underrun        = underrun_q;
    assign oversize        = oversize_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer. Two instances share one stimulus
// driver: dut_pad (default parameters) and dut_raw (PAD_EN=0); 'sel' routes
// in_valid to one of them and picks which one the monitor observes.
// Expected wire bytes come from a frame-level model: preamble/SFD, the
// payload, zero pad to 60 bytes, table-driven CRC-32 FCS.
module tb_gmii_tx_framer;
    logic       gmii_clk;
    logic       rst;
    logic       sel;
    logic       drv_valid, drv_sop, drv_eop;
    logic [7:0] drv_data;

    gmii_tx_framer_if if_pad();
    gmii_tx_framer_if if_raw();

    assign if_pad.in_valid = drv_valid & ~sel;
    assign if_raw.in_valid = drv_valid & sel;
    assign if_pad.in_sop   = drv_sop;
    assign if_raw.in_sop   = drv_sop;
    assign if_pad.in_eop   = drv_eop;
    assign if_raw.in_eop   = drv_eop;
    assign if_pad.in_data  = drv_data;
    assign if_raw.in_data  = drv_data;

    logic       den_pad, fd_pad, ur_pad, ov_pad;
    logic       den_raw, fd_raw, ur_raw, ov_raw;
    logic [7:0] dout_pad, dout_raw;

    gmii_tx_framer dut_pad (
        .gmii_clk(gmii_clk), .rst(rst), .stream(if_pad),
        .gmii_den(den_pad), .gmii_dout(dout_pad),
        .frame_done(fd_pad), .underrun(ur_pad), .oversize(ov_pad)
    );

    gmii_tx_framer #(.PAD_EN(0)) dut_raw (
        .gmii_clk(gmii_clk), .rst(rst), .stream(if_raw),
        .gmii_den(den_raw), .gmii_dout(dout_raw),
        .frame_done(fd_raw), .underrun(ur_raw), .oversize(ov_raw)
    );

    logic       mon_den, mon_ready, mon_fd, mon_ur, mon_ov;
    logic [7:0] mon_dout;
    assign mon_den   = sel ? den_raw : den_pad;
    assign mon_dout  = sel ? dout_raw : dout_pad;
    assign mon_ready = sel ? if_raw.in_ready : if_pad.in_ready;
    assign mon_fd    = sel ? fd_raw : fd_pad;
    assign mon_ur    = sel ? ur_raw : ur_pad;
    assign mon_ov    = sel ? ov_raw : ov_pad;

    initial begin
        gmii_clk = 1'b0;
        forever #4 gmii_clk = ~gmii_clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge gmii_clk);
        cyc++;
    end

    // Monitor: owns all of these; the stimulus side only reads them.
    logic [7:0] cap_q[$];
    int         gaps[$];
    int         rises = 0, rise_cyc = 0, low_run = 0;
    int         fd_cnt = 0, ur_cnt = 0, ov_cnt = 0;
    int         dout_bad = 0, ready_low = 0;
    bit         prev_den = 1'b0;

    initial forever begin
        @(negedge gmii_clk);
        if (mon_den === 1'b1) begin
            cap_q.push_back(mon_dout);
            if (!prev_den) begin
                rises++;
                rise_cyc = cyc;
                gaps.push_back(low_run);
            end
            low_run  = 0;
            prev_den = 1'b1;
        end else begin
            low_run++;
            if (mon_dout !== 8'h00) dout_bad++;
            if (mon_ready === 1'b1) ready_low++;
            prev_den = 1'b0;
        end
        if (mon_fd === 1'b1) fd_cnt++;
        if (mon_ur === 1'b1) ur_cnt++;
        if (mon_ov === 1'b1) ov_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Reference model
    logic [31:0] crc_tab[256];
    logic [7:0]  pay_q[$];
    logic [7:0]  exp_q[$];
    int          eop_cyc = 0;

    task automatic build_tab();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
    endtask

    // Appends the expected wire image of pay_q. keep >= 0 means the frame is
    // cut after that many payload bytes with no pad or FCS.
    task automatic build_exp(input bit pad_en, input int keep);
        logic [7:0]  body[$];
        logic [31:0] crc;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        if (keep >= 0) begin
            for (int i = 0; i < keep; i++) exp_q.push_back(pay_q[i]);
        end else begin
            body = pay_q;
            if (pad_en) while (body.size() < 60) body.push_back(8'h00);
            crc = 32'hFFFFFFFF;
            foreach (body[i]) begin
                crc = crc_tab[(crc[7:0] ^ body[i])] ^ (crc >> 8);
                exp_q.push_back(body[i]);
            end
            crc = ~crc;
            for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
        end
    endtask

    task automatic compare_capture(input string tag, input int base);
        int n, bad;
        n   = cap_q.size() - base;
        bad = 0;
        check({tag, "_len"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (cap_q[base + i] !== exp_q[i]) bad++;
        check({tag, "_bytes"}, 64'(bad), 64'd0);
    endtask

    // Stimulus
    task automatic idle_inputs();
        drv_valid = 1'b0;
        drv_sop   = 1'b0;
        drv_eop   = 1'b0;
        drv_data  = 8'h00;
    endtask

    task automatic wait_idle(input int n);
        @(negedge gmii_clk);
        #1 idle_inputs();
        repeat (n) @(negedge gmii_clk);
    endtask

    task automatic random_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    // Sends pay_q contiguously. drop_after >= 0 withholds in_valid for
    // drop_len cycles once that many bytes are taken; rst_at >= 0 raises rst
    // for one cycle once that many bytes are taken and stops there.
    task automatic send_frame(input int drop_after, input int drop_len, input int rst_at,
                              output int acc_n);
        int idx, gone, guard;
        bit stop;
        idx = 0; gone = 0; guard = 0; stop = 1'b0;
        while (idx < pay_q.size() && guard < 4000 && !stop) begin
            @(negedge gmii_clk);
            #1;
            if (rst_at >= 0 && idx == rst_at) begin
                rst       = 1'b1;
                drv_valid = 1'b1;
                drv_sop   = 1'b0;
                drv_eop   = 1'b0;
                drv_data  = pay_q[idx];
                #1 check("rst_cycle_ready", 64'(mon_ready), 64'd0);
                stop = 1'b1;
            end else if (drop_after >= 0 && idx == drop_after && gone < drop_len) begin
                drv_valid = 1'b0;
                gone++;
                #1;
            end else begin
                drv_valid = 1'b1;
                drv_data  = pay_q[idx];
                drv_sop   = (idx == 0);
                drv_eop   = (idx == pay_q.size() - 1);
                #1;
                if (mon_ready === 1'b1) begin
                    if (drv_eop) eop_cyc = cyc;
                    idx++;
                end
            end
            guard++;
        end
        acc_n = idx;
    endtask

    task automatic send_stray(input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge gmii_clk);
            #1;
            drv_valid = 1'b1;
            drv_sop   = 1'b0;
            drv_eop   = 1'($urandom);
            drv_data  = 8'($urandom);
            #1;
            if (mon_ready === 1'b1) acc++;
        end
        check("stray_accepted", 64'(acc), 64'(n));
    endtask

    initial begin
        int acc, cb, rb, fb, ub, ob, gb, lb, first_eop, sop_cyc, gap, n;

        build_tab();
        sel = 1'b0;
        rst = 1'b1;
        idle_inputs();
        drv_valid = 1'b1;  // would be a takeable stray byte if not in reset
        repeat (3) @(negedge gmii_clk);
        #2;
        check("reset_ready", 64'(mon_ready), 64'd0);
        check("reset_den", 64'(mon_den), 64'd0);
        check("reset_dout", 64'(mon_dout), 64'd0);
        check("reset_pulses", 64'({mon_fd, mon_ur, mon_ov}), 64'd0);
        @(negedge gmii_clk);
        #1 rst = 1'b0;
        wait_idle(3);

        // Known-answer FCS on the unpadded instance
        sel = 1'b1;
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        cb = cap_q.size(); rb = rises; fb = fd_cnt;
        send_frame(-1, 0, -1, acc);
        check("kat_accepted", 64'(acc), 64'd9);
        wait_idle(40);
        compare_capture("kat", cb);
        check("kat_runs", 64'(rises - rb), 64'd1);
        check("kat_frame_done", 64'(fd_cnt - fb), 64'd1);

        // Minimum-size padding
        sel = 1'b0;
        wait_idle(2);
        pay_q.delete();
        pay_q.push_back(8'hAA);
        exp_q.delete();
        build_exp(1'b1, -1);
        cb = cap_q.size(); rb = rises; fb = fd_cnt;
        send_frame(-1, 0, -1, acc);
        wait_idle(100);
        compare_capture("pad", cb);
        check("pad_runs", 64'(rises - rb), 64'd1);
        check("pad_frame_done", 64'(fd_cnt - fb), 64'd1);

        // Random frames on both instances, with stray bytes ahead of sop
        for (int f = 0; f < 6; f++) begin
            wait_idle(2);
            sel = 1'(f % 2);
            send_stray(int'($urandom_range(1, 3)));
            random_payload(int'($urandom_range(1, 150)));
            exp_q.delete();
            build_exp(!sel, -1);
            cb = cap_q.size(); rb = rises; fb = fd_cnt;
            send_frame(-1, 0, -1, acc);
            check("rand_accepted", 64'(acc), 64'(pay_q.size()));
            wait_idle(90);
            compare_capture("rand", cb);
            check("rand_runs", 64'(rises - rb), 64'd1);
            check("rand_frame_done", 64'(fd_cnt - fb), 64'd1);
        end

        // Back-to-back frames: second sop pending through the gap
        sel = 1'b0;
        wait_idle(2);
        exp_q.delete();
        cb = cap_q.size(); rb = rises; fb = fd_cnt; gb = gaps.size(); lb = ready_low;
        random_payload(100);
        build_exp(1'b1, -1);
        send_frame(-1, 0, -1, acc);
        random_payload(100);
        build_exp(1'b1, -1);
        send_frame(-1, 0, -1, acc);
        wait_idle(60);
        compare_capture("b2b", cb);
        check("b2b_runs", 64'(rises - rb), 64'd2);
        gap = (gaps.size() > gb + 1) ? gaps[gb + 1] : -1;
        check("b2b_gap", 64'(gap), 64'd12);
        check("b2b_ready_in_gap", 64'(ready_low - lb), 64'd0);
        check("b2b_frame_done", 64'(fd_cnt - fb), 64'd2);

        // Underrun after 20 bytes, followed immediately by a good frame
        wait_idle(2);
        exp_q.delete();
        cb = cap_q.size(); fb = fd_cnt; ub = ur_cnt;
        random_payload(100);
        build_exp(1'b1, 20);
        send_frame(20, 2, -1, acc);
        check("ur_accepted", 64'(acc), 64'd100);
        first_eop = eop_cyc;
        random_payload(40);
        build_exp(1'b1, -1);
        rb = rises;
        send_frame(-1, 0, -1, acc);
        check("ur_no_frame_done", 64'(fd_cnt - fb), 64'd0);
        wait_idle(90);
        compare_capture("ur", cb);
        check("ur_pulses", 64'(ur_cnt - ub), 64'd1);
        check("ur_idle_after_discard", 64'(rise_cyc - first_eop >= 13), 64'd1);
        check("ur_next_runs", 64'(rises - rb), 64'd1);

        // Oversize: 1600-byte packet, cut at 1514 payload bytes
        wait_idle(2);
        exp_q.delete();
        cb = cap_q.size(); rb = rises; fb = fd_cnt; ob = ov_cnt;
        random_payload(1600);
        build_exp(1'b1, 1514);
        send_frame(-1, 0, -1, acc);
        check("ov_accepted", 64'(acc), 64'd1600);
        wait_idle(40);
        compare_capture("ov", cb);
        check("ov_runs", 64'(rises - rb), 64'd1);
        check("ov_pulses", 64'(ov_cnt - ob), 64'd1);
        check("ov_no_frame_done", 64'(fd_cnt - fb), 64'd0);

        // Reset at payload byte 30, fresh sop right after
        wait_idle(2);
        random_payload(100);
        send_frame(-1, 0, 30, acc);
        check("rst_accepted", 64'(acc), 64'd30);
        @(negedge gmii_clk);
        #1;
        rst = 1'b0;
        random_payload(50);
        drv_valid = 1'b1;
        drv_sop   = 1'b1;
        drv_eop   = 1'b0;
        drv_data  = pay_q[0];
        #1;
        check("rst_next_den", 64'(mon_den), 64'd0);
        check("rst_next_ready", 64'(mon_ready), 64'd0);
        sop_cyc = cyc;
        exp_q.delete();
        build_exp(1'b1, -1);
        cb = cap_q.size(); rb = rises;
        send_frame(-1, 0, -1, acc);
        wait_idle(90);
        compare_capture("rst_fresh", cb);
        check("rst_fresh_runs", 64'(rises - rb), 64'd1);
        check("rst_preamble_start", 64'(rise_cyc), 64'(sop_cyc + 1));

        n = dout_bad;
        check("dout_zero_when_den_low", 64'(n), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
